// File: rtl/raizing_cen_pkg.sv
// Shared constants, limits and helpers for the fractional clock-enable bank.
package raizing_cen_pkg;

    // Default width of the n/m ratio operands and of each accumulator.
    localparam int unsigned WC_DEFAULT = 17;

    // Supported channel count and divider tap count per channel.
    localparam int unsigned CH_MIN = 1;
    localparam int unsigned CH_MAX = 8;
    localparam int unsigned W_MIN  = 1;
    localparam int unsigned W_MAX  = 4;

    // Accumulator update selected each cycle by a channel.
    typedef enum logic [1:0] {
        ACC_HOLD,   // frozen by pause
        ACC_CLEAR,  // channel disabled or new ratio being applied
        ACC_STEP,   // no tick: acc <= acc + n
        ACC_WRAP    // tick: acc <= acc + n - m
    } acc_op_e;

    // Flat bit index of tap k of channel c in the cen/cenb vectors.
    function automatic int unsigned tap_idx(input int unsigned c,
                                            input int unsigned k,
                                            input int unsigned w);
        return c * w + k;
    endfunction

    // Width of a channel selector; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/raizing_cen_chan.sv
// One fractional clock-enable channel: n/m accumulator, binary tap counter,
// shadow ratio registers and the logic that applies a pending ratio.
module raizing_cen_chan
    import raizing_cen_pkg::*;
#(
    parameter int unsigned   WC    = WC_DEFAULT,
    parameter int unsigned   W     = 2,
    parameter logic [WC-1:0] N_RST = WC'(1),
    parameter logic [WC-1:0] M_RST = WC'(2)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          pause_i,
    input  logic          wr_i,
    input  logic [WC-1:0] wr_n_i,
    input  logic [WC-1:0] wr_m_i,
    output logic          pend_o,
    output logic [W-1:0]  cen_o,
    output logic [W-1:0]  cenb_o
);

    // Tap counter needs W-1 bits; keep one bit when W is 1 (held at zero).
    localparam int unsigned TW = (W > 1) ? W - 1 : 1;

    logic [WC-1:0] n_q,   n_d;
    logic [WC-1:0] m_q,   m_d;
    logic [WC-1:0] sn_q,  sn_d;
    logic [WC-1:0] sm_q,  sm_d;
    logic [WC-1:0] acc_q, acc_d;
    logic [TW-1:0] tap_q, tap_d;
    logic          pend_q, pend_d;
    logic [W-1:0]  cen_q,  cen_d;
    logic [W-1:0]  cenb_q, cenb_d;

    logic          run;
    logic [WC:0]   sum;
    logic [WC-1:0] m_half;
    logic          half_ok;
    logic          tick;
    logic          half;
    logic          apply;
    logic [W-1:0]  tap_ok;
    acc_op_e       acc_op;

    // Compare, tap decode, pending-ratio application and shadow write.
    always_comb begin
        run     = en_i && !pause_i;
        sum     = {1'b0, acc_q} + {1'b0, n_q};
        m_half  = m_q >> 1;
        // Half-phase only makes sense when at most one tick per half period.
        half_ok = ({n_q, 1'b0} <= {1'b0, m_q});
        tick    = run && (sum >= {1'b0, m_q});
        half    = run && !tick && half_ok
                  && (acc_q < m_half) && (sum >= {1'b0, m_half});
        // A disabled channel picks up its pending ratio without waiting.
        apply   = pend_q && !pause_i && (tick || !en_i);

        for (int unsigned k = 0; k < W; k++) begin
            tap_ok[k] = &(tap_q | ~TW'((1 << k) - 1));
        end

        if (pause_i) begin
            acc_op = ACC_HOLD;
        end else if (!en_i || apply) begin
            acc_op = ACC_CLEAR;
        end else if (tick) begin
            acc_op = ACC_WRAP;
        end else begin
            acc_op = ACC_STEP;
        end

        acc_d  = acc_q;
        tap_d  = tap_q;
        n_d    = n_q;
        m_d    = m_q;
        sn_d   = sn_q;
        sm_d   = sm_q;
        pend_d = pend_q;

        case (acc_op)
            ACC_CLEAR: begin
                acc_d = '0;
                tap_d = '0;
            end
            ACC_WRAP: begin
                acc_d = WC'(sum - {1'b0, m_q});
                tap_d = (W > 1) ? tap_q + TW'(1) : '0;
            end
            ACC_STEP: begin
                acc_d = WC'(sum);
            end
            default: begin
            end
        endcase

        if (apply) begin
            n_d    = sn_q;
            m_d    = sm_q;
            pend_d = 1'b0;
        end

        // A write in the applying cycle still lands and stays pending.
        if (wr_i) begin
            sn_d   = wr_n_i;
            sm_d   = wr_m_i;
            pend_d = 1'b1;
        end

        cen_d  = tick ? tap_ok : '0;
        cenb_d = half ? tap_ok : '0;
    end

    // Channel state and registered enable outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            n_q    <= N_RST;
            m_q    <= M_RST;
            sn_q   <= N_RST;
            sm_q   <= M_RST;
            acc_q  <= '0;
            tap_q  <= '0;
            pend_q <= 1'b0;
            cen_q  <= '0;
            cenb_q <= '0;
        end else begin
            n_q    <= n_d;
            m_q    <= m_d;
            sn_q   <= sn_d;
            sm_q   <= sm_d;
            acc_q  <= acc_d;
            tap_q  <= tap_d;
            pend_q <= pend_d;
            cen_q  <= cen_d;
            cenb_q <= cenb_d;
        end
    end

    assign pend_o = pend_q;
    assign cen_o  = cen_q;
    assign cenb_o = cenb_q;

endmodule

// File: rtl/raizing_cen_bank.sv
// Bank of CH independent fractional clock-enable channels sharing one
// ratio-write port; each channel provides W binary-divided taps.
module raizing_cen_bank
    import raizing_cen_pkg::*;
#(
    parameter int unsigned      CH     = 4,
    parameter int unsigned      WC     = WC_DEFAULT,
    parameter int unsigned      W      = 2,
    parameter logic [CH*WC-1:0] N_INIT = {CH{WC'(1)}},
    parameter logic [CH*WC-1:0] M_INIT = {CH{WC'(2)}}
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [CH-1:0]             ch_en,
    input  logic                      pause,
    input  logic                      cfg_we,
    input  logic [sel_width(CH)-1:0]  cfg_sel,
    input  logic [WC-1:0]             cfg_n,
    input  logic [WC-1:0]             cfg_m,
    output logic                      cfg_err,
    output logic [CH-1:0]             cfg_pend,
    output logic [CH*W-1:0]           cen,
    output logic [CH*W-1:0]           cenb
);

    if (CH < CH_MIN || CH > CH_MAX) begin : g_bad_ch
        $error("raizing_cen_bank: CH outside supported range");
    end
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("raizing_cen_bank: W outside supported range");
    end

    logic          cfg_ok;
    logic [CH-1:0] wr;
    logic          cfg_err_q, cfg_err_d;

    // Validate the write and steer the strobe to the selected channel.
    always_comb begin
        cfg_ok = (cfg_n != '0) && (cfg_m != '0) && (cfg_n <= cfg_m)
                 && (32'(cfg_sel) < CH);
        for (int unsigned c = 0; c < CH; c++) begin
            wr[c] = cfg_we && cfg_ok && (32'(cfg_sel) == c);
        end
        cfg_err_d = cfg_we && !cfg_ok;
    end

    // Rejected-write flag, visible for one cycle after the write.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        raizing_cen_chan #(
            .WC    (WC),
            .W     (W),
            .N_RST (N_INIT[c*WC +: WC]),
            .M_RST (M_INIT[c*WC +: WC])
        ) u_chan (
            .clk_i   (CLK),
            .rst_ni  (RESETn),
            .en_i    (ch_en[c]),
            .pause_i (pause),
            .wr_i    (wr[c]),
            .wr_n_i  (cfg_n),
            .wr_m_i  (cfg_m),
            .pend_o  (cfg_pend[c]),
            .cen_o   (cen[tap_idx(c, 0, W) +: W]),
            .cenb_o  (cenb[tap_idx(c, 0, W) +: W])
        );
    end

endmodule

// File: tb/tb_raizing_cen_bank.sv
// Self-checking bench for raizing_cen_bank: directed cadence scenarios plus
// randomized traffic, all checked against a closed-form ratio model.
module tb_raizing_cen_bank;

    localparam int CH = 4;
    localparam int WC = 17;
    localparam int W  = 2;
    localparam int NB = CH * W;

    logic           CLK = 1'b0;
    logic           RESETn;
    logic [CH-1:0]  ch_en;
    logic           pause;
    logic           cfg_we;
    logic [1:0]     cfg_sel;
    logic [WC-1:0]  cfg_n;
    logic [WC-1:0]  cfg_m;
    logic           cfg_err;
    logic [CH-1:0]  cfg_pend;
    logic [NB-1:0]  cen;
    logic [NB-1:0]  cenb;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reset ratios per channel (index = channel).
    longint ini_n [CH] = '{1, 8, 1, 3};
    longint ini_m [CH] = '{7, 189, 2, 10};

    // Model: active and shadow ratio, pending flag, compares since fresh start.
    longint mn [CH], mm [CH], msn [CH], msm [CH], cnt [CH];
    bit     mpend [CH];
    logic [NB-1:0] e_cen, e_cenb;
    logic          e_err;
    logic [CH-1:0] e_pend;

    raizing_cen_bank #(
        .CH     (CH),
        .WC     (WC),
        .W      (W),
        .N_INIT ({17'd3, 17'd1, 17'd8, 17'd1}),
        .M_INIT ({17'd10, 17'd2, 17'd189, 17'd7})
    ) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .ch_en    (ch_en),
        .pause    (pause),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_n    (cfg_n),
        .cfg_m    (cfg_m),
        .cfg_err  (cfg_err),
        .cfg_pend (cfg_pend),
        .cen      (cen),
        .cenb     (cenb)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        longint b, a, ac, tb, pw;
        bit     tk, hf, ok;
        int     s;
        if (!RESETn) begin
            for (int c = 0; c < CH; c++) begin
                mn[c] = ini_n[c]; mm[c] = ini_m[c];
                msn[c] = ini_n[c]; msm[c] = ini_m[c];
                cnt[c] = 0; mpend[c] = 0;
            end
            e_cen = '0; e_cenb = '0; e_err = 1'b0;
        end else begin
            e_cen = '0; e_cenb = '0;
            for (int c = 0; c < CH; c++) begin
                if (!pause) begin
                    if (ch_en[c]) begin
                        cnt[c]++;
                        b  = ((cnt[c] - 1) * mn[c]) / mm[c];
                        a  = (cnt[c] * mn[c]) / mm[c];
                        tk = (a > b);
                        ac = ((cnt[c] - 1) * mn[c]) % mm[c];
                        hf = !tk && (2 * mn[c] <= mm[c]) && (ac < mm[c] / 2)
                             && (ac + mn[c] >= mm[c] / 2);
                        tb = b % (longint'(1) << (W - 1));
                        for (int k = 0; k < W; k++) begin
                            pw = longint'(1) << k;
                            if (tb % pw == pw - 1) begin
                                e_cen[c*W+k]  = tk;
                                e_cenb[c*W+k] = hf;
                            end
                        end
                        if (tk && mpend[c]) begin
                            mn[c] = msn[c]; mm[c] = msm[c];
                            mpend[c] = 0; cnt[c] = 0;
                        end
                    end else begin
                        cnt[c] = 0;
                        if (mpend[c]) begin
                            mn[c] = msn[c]; mm[c] = msm[c];
                            mpend[c] = 0;
                        end
                    end
                end
            end
            ok = (cfg_n != 0) && (cfg_m != 0) && (cfg_n <= cfg_m) && (int'(cfg_sel) < CH);
            if (cfg_we && ok) begin
                s = int'(cfg_sel);
                msn[s] = longint'(cfg_n); msm[s] = longint'(cfg_m);
                mpend[s] = 1;
            end
            e_err = cfg_we && !ok;
        end
        for (int c = 0; c < CH; c++) e_pend[c] = mpend[c];
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        cyc++;
        chk("cen",  longint'(cen),      longint'(e_cen));
        chk("cenb", longint'(cenb),     longint'(e_cenb));
        chk("pend", longint'(cfg_pend), longint'(e_pend));
        chk("err",  longint'(cfg_err),  longint'(e_err));
    endtask

    task automatic wait_cen0(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (cen[0]) begin
                t = cyc;
                break;
            end
        end
        chk("wait_cen0_found", longint'(t >= 0), 1);
    endtask

    initial begin
        int t_rel, j, fb, f1, f2, c0, c10, c11, s, sb, t0, t1, tD, tR, idx;

        RESETn = 1'b0; ch_en = '0; pause = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_n = '0; cfg_m = '0;
        repeat (3) cycle();
        chk("rst_out", longint'({cen, cenb, cfg_pend, cfg_err}), 0);

        // Cadence from reset release: ch0 1/7, ch1 8/189.
        RESETn = 1'b1; ch_en = '1; t_rel = cyc;
        fb = -1; f1 = -1; f2 = -1; c0 = 0; c10 = 0; c11 = 0;
        for (int i = 0; i < 1890; i++) begin
            cycle();
            j = cyc - t_rel;
            if (cenb[0] && fb < 0) fb = j;
            if (cen[0]) begin
                if (f1 < 0) f1 = j;
                else if (f2 < 0) f2 = j;
            end
            c0  += int'(cen[0]);
            c10 += int'(cen[2]);
            c11 += int'(cen[3]);
        end
        chk("r37_half_cyc", fb, 3);
        chk("r37_tick_cyc", f1, 7);
        chk("r37_period",   f2 - f1, 7);
        chk("ch0_count",    c0, 270);
        chk("r38_tap0",     c10, 80);
        chk("r38_tap1",     c11, 40);

        // n == m on ch2: tick every cycle, no half.
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_n = 17'd5; cfg_m = 17'd5;
        cycle();
        cfg_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!cfg_pend[2]) break;
        end
        chk("r42_applied", longint'(cfg_pend[2]), 0);
        s = 0; sb = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            s  += int'(cen[4]);
            sb += int'(cenb[4]);
        end
        chk("r42_cen", s, 50);
        chk("r42_cenb", sb, 0);

        // Rejected write, then last-write-wins on ch1.
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_n = 17'd0; cfg_m = 17'd7;
        cycle();
        cfg_we = 1'b0;
        chk("r39_err", longint'(cfg_err), 1);
        chk("r39_pend", longint'(cfg_pend), 0);
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_n = 17'd3; cfg_m = 17'd20;
        cycle();
        cfg_n = 17'd5;
        cycle();
        cfg_we = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (!cfg_pend[1]) break;
        end
        chk("r39_applied", longint'(cfg_pend[1]), 0);
        s = 0;
        for (int i = 0; i < 80; i++) begin
            cycle();
            s += int'(cen[2]);
        end
        chk("r39_last_wins", s, 20);

        // Pause for 10 cycles mid-period on ch0.
        wait_cen0(t0);
        cycle(); cycle();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("r40_quiet", longint'({cen, cenb}), 0);
        end
        pause = 1'b0;
        wait_cen0(t1);
        chk("r40_delay", t1 - t0, 17);

        // One-cycle enable drop on ch0.
        wait_cen0(t0);
        repeat (3) cycle();
        ch_en[0] = 1'b0;
        cycle();
        chk("r41_en_quiet", longint'({cen[1:0], cenb[1:0]}), 0);
        tD = cyc;
        ch_en[0] = 1'b1;
        wait_cen0(t1);
        chk("r41_en_restart", t1 - tD, 7);

        // One-cycle reset overriding pause and a write.
        wait_cen0(t0);
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_n = 17'd2; cfg_m = 17'd9;
        cycle();
        cfg_we = 1'b0;
        cycle();
        RESETn = 1'b0; pause = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd3;
        cycle();
        chk("r41_rst_quiet", longint'({cen, cenb, cfg_pend}), 0);
        tR = cyc;
        RESETn = 1'b1; pause = 1'b0; cfg_we = 1'b0;
        wait_cen0(t1);
        chk("r41_rst_restart", t1 - tR, 7);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            RESETn = ($urandom_range(0, 199) != 0);
            pause  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) begin
                idx = int'($urandom_range(0, CH - 1));
                ch_en[idx] = ~ch_en[idx];
            end
            cfg_we  = ($urandom_range(0, 3) == 0);
            cfg_sel = 2'($urandom_range(0, 3));
            cfg_n   = 17'($urandom_range(0, 12));
            cfg_m   = 17'($urandom_range(0, 30));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/raizing_cen_bank.md
RAIZING_CEN_BANK -- requirements
Module: raizing_cen_bank

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent fractional clock-enable channels, 1..8.
REQ-002 SHALL have parameter WC, default 17: width of the n/m ratio operands and the accumulator.
REQ-003 SHALL have parameter W, default 2: binary divider taps per channel, 1..4.
REQ-004 SHALL have parameters N_INIT and M_INIT, each CH*WC bits, default 1 and 2 per channel: reset ratio values.
REQ-005 SHALL have port CLK, input, 1: the single clock, 96 MHz in use; all logic is clocked on the rising edge.
REQ-006 SHALL have port RESETn, input, 1: synchronous active-low reset.
REQ-007 SHALL have port ch_en, input, CH: per-channel run enable.
REQ-008 SHALL have port pause, input, 1: global freeze.
REQ-009 SHALL have port cfg_we, input, 1: one-cycle ratio write strobe.
REQ-010 SHALL have port cfg_sel, input, clog2(CH) (min 1): target channel of the write.
REQ-011 SHALL have ports cfg_n and cfg_m, input, WC each: new ratio numerator and denominator.
REQ-012 SHALL have port cfg_err, output, 1: one-cycle pulse marking a rejected write.
REQ-013 SHALL have port cfg_pend, output, CH: shadow ratio written but not yet applied.
REQ-014 SHALL have ports cen and cenb, output, CH*W each: main and half-phase enables, with channel c tap k at bit index c*W+k.

Function
REQ-015 SHALL evaluate sum = acc + n per running channel each cycle, WC+1 bits wide, with no truncation.
REQ-016 SHALL, when sum >= m, raise tick and load acc <= sum - m; otherwise it SHALL load acc <= sum.
REQ-017 SHALL raise half when tick is low, acc < (m>>1) and sum >= (m>>1); when n*2 > m, half SHALL never fire.
REQ-018 SHALL keep a W-1 bit tap counter per channel, incremented on tick and wrapping naturally.
REQ-019 SHALL drive cen[c*W+k] = tick && (low k bits of the pre-increment tap counter all ones), so tap k pulses once per 2^k ticks.
REQ-020 SHALL drive cenb[c*W+k] = half && (the same counter condition as REQ-019).
REQ-021 SHALL register all cen/cenb outputs: one-cycle-wide pulses, one cycle after the accumulator compare.
REQ-022 SHALL, with ch_en[c] low, hold that channel's acc and tap counter at 0 and its outputs at 0.
REQ-023 SHALL start the first compare on the first cycle ch_en[c] is high.
REQ-024 SHALL, with pause high, hold all acc, tap counter and pending state and force all outputs to 0.
REQ-025 SHALL resume from the held acc and tap counter values when pause deasserts.
REQ-026 SHALL accept a write only if cfg_n != 0, cfg_m != 0, cfg_n <= cfg_m and cfg_sel < CH.
REQ-027 SHALL, on an accepted write, store the value in the channel shadow registers and set cfg_pend[c].
REQ-028 SHALL, on a rejected write, leave all channel state unchanged and pulse cfg_err on the following cycle.
REQ-029 SHALL let the last accepted write win when a channel is written more than once before it is applied.
REQ-030 SHALL apply a pending ratio on the cycle the channel ticks: that tick is emitted normally, then n/m load from shadow, acc <= 0, tap counter <= 0 and cfg_pend clears.
REQ-031 SHALL apply a pending ratio on the next cycle when the channel is disabled.
REQ-032 SHALL let a write that coincides with the applying tick land in the shadow registers and keep cfg_pend set.

Reset
REQ-033 SHALL, with RESETn low on a clock edge, set n/m and the shadow registers to N_INIT/M_INIT, and set acc, tap counters, cfg_pend, cfg_err, cen and cenb to 0.
REQ-034 SHALL let reset override pause, ch_en and cfg_we, and abandon any pending ratio mid-operation.

Structure
REQ-035 SHALL place the WC default, the channel count limits and the tap index helper in package raizing_cen_pkg.
REQ-036 SHALL implement one channel as sub-module raizing_cen_chan (accumulator, tap counter, shadow, apply logic), instantiated CH times by generate.

Verification
REQ-037 SHALL check that n=1, m=7 with ch_en high from reset release gives half on compare cycle 3, tick on cycle 7, and cen/cenb one cycle later, repeating every 7 cycles.
REQ-038 SHALL check that n=8, m=189, W=2 gives exactly 8 cen[0] and 4 cen[1] pulses per 189 cycles over 10 periods.
REQ-039 SHALL check that writing n=0 gives a cfg_err pulse, cfg_pend unchanged and the cadence unchanged; writing 3 then 5 before a tick applies only 5.
REQ-040 SHALL check that 10 cycles of pause mid-period yield no pulses, and the next tick arrives delayed by exactly 10 cycles.
REQ-041 SHALL check that dropping ch_en for 1 cycle, or asserting RESETn low for 1 cycle mid-period, gives outputs 0, then a fresh cadence from acc=0.
REQ-042 SHALL check that n=m gives cen[0] every cycle and cenb never.
